// File: rtl/alu_issue_arb.sv
// Issue arbiter feeding one ALU input register from NUM_REQ issue queues.
// Round-robin selection, overridden by the lowest-index requester that has waited STARVE_LIMIT cycles.
module alu_issue_arb #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_W    = 128,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           alu_stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           issue_to_alu_valid,
  output logic [PAYLOAD_W-1:0]           issue_inst
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   starved;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     cand;
  logic                 found;
  logic                 xfer;
  logic [PAYLOAD_W-1:0] win_payload;

  // Winner selection: a starved requester beats the round-robin scan.
  always_comb begin
    starved = '0;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    grant   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      starved[i] = req_valid[i] && (wait_cnt[i] == LIMIT);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && starved[i]) begin
        found   = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    xfer = found && !alu_stall && !flush && !reset;
    if (xfer) grant[win_idx] = 1'b1;
  end

  always_comb begin
    win_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // Counters clear on flush/grant/idle, freeze under stall, otherwise saturate at LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (flush || grant[i] || !req_valid[i]) begin
          wait_cnt[i] <= '0;
        end else if (!alu_stall && wait_cnt[i] != LIMIT) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_to_alu_valid <= 1'b0;
      issue_inst         <= '0;
    end else if (flush) begin
      issue_to_alu_valid <= 1'b0;
    end else if (!alu_stall) begin
      issue_to_alu_valid <= xfer;
      if (xfer) issue_inst <= win_payload;
    end
  end

endmodule
